fpu_op_sequencer: RTL and testbench
===================================

FPU_OP_SEQUENCER -- requirements
Module: fpu_op_sequencer

Interface
REQ-001 Parameter: FPU_LATENCY, default 4, number of cycles the downstream fpu needs from stable operands to valid data/status; legal range 1..15.
REQ-002 clock100KHz  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 = in reset.
REQ-004 in_valid  input  1  upstream operand pair valid.
REQ-005 in_ready  output  1  sequencer accepts a pair this cycle.
REQ-006 in_a, in_b  input  32 each  IEEE-754 single operands A, B.
REQ-007 op_A_out, op_B_out  output  32 each  operands driven to fpu op_A_in/op_B_in.
REQ-008 fpu_data_in  input  32  fpu data_out.
REQ-009 fpu_status_in  input  4  fpu status_out: [3] overflow, [2] underflow, [1] inexact, [0] exact.
REQ-010 res_valid  output  1  captured result available.
REQ-011 res_ready  input  1  downstream consumes result.
REQ-012 res_data  output  32  captured fpu result.
REQ-013 res_status  output  4  captured fpu status.
REQ-014 err_clr  input  1  synchronous clear of err_count.
REQ-015 err_count  output  8  count of results with overflow or underflow.

Function
REQ-016 States SHALL be IDLE, WAIT, HOLD; reset state IDLE.
REQ-017 in_ready SHALL equal (state==IDLE) and (reset==1); in_ready SHALL be 0 while reset is asserted.
REQ-018 In IDLE, in_valid&&in_ready at an edge SHALL load in_a/in_b into op_A_out/op_B_out, load wait counter with FPU_LATENCY-1, and move to WAIT.
REQ-019 In IDLE without in_valid, op_A_out/op_B_out SHALL hold their last values.
REQ-020 op_A_out/op_B_out SHALL remain stable through WAIT and HOLD; in_a/in_b changes there SHALL be ignored.
REQ-021 In WAIT, counter SHALL decrement each edge; at the edge where counter==0, fpu_data_in/fpu_status_in SHALL be sampled into res_data/res_status, res_valid SHALL be set, and state SHALL move to HOLD.
REQ-022 WAIT SHALL therefore last exactly FPU_LATENCY cycles; the first res_valid cycle is the FPU_LATENCY+1 cycle after the acceptance edge.
REQ-023 In HOLD, res_valid=1 and res_data/res_status SHALL be stable until an edge with res_ready=1, which SHALL clear res_valid and move to IDLE.
REQ-024 res_ready outside HOLD SHALL have no effect.
REQ-025 No new pair SHALL be accepted in the same edge a result is consumed; minimum issue interval is FPU_LATENCY+2 cycles.
REQ-026 res_data/res_status SHALL keep last captured values after consumption.
REQ-027 On each capture edge (REQ-021), if fpu_status_in[3] or fpu_status_in[2] is 1, err_count SHALL increment by 1, saturating at 255.
REQ-028 err_clr=1 at an edge SHALL set err_count to 0; if it coincides with an incrementing capture, clear wins and result is 0.
REQ-029 err_clr SHALL NOT affect state, res_* or op_* outputs.

Reset
REQ-030 While reset==0: state IDLE, counter 0, op_A_out=op_B_out=0, res_valid=0, res_data=0, res_status=0, err_count=0, in_ready=0.
REQ-031 Reset asserted mid-WAIT or mid-HOLD SHALL abort the operation immediately, discarding the pending result.
REQ-032 First acceptance SHALL be possible at the first rising edge after reset returns to 1.

Verification
REQ-033 Reset, then in_a=0x40400000, in_b=0x3FC00000, in_valid one cycle, FPU model returns 0x40900000/4'b0001 after 4 cycles -> op_*_out latched next edge, in_ready=0 for 6 cycles, res_valid rises exactly 5 cycles after acceptance with res_data=0x40900000, res_status=0001, err_count=0.
REQ-034 Hold res_ready=0 for 10 cycles in HOLD while toggling in_a and fpu_data_in -> res_valid, res_data, op_A_out unchanged; in_valid not accepted; res_ready=1 -> IDLE next edge, in_ready=1.
REQ-035 Three captures with status 4'b1000, 4'b0100, 4'b0010 -> err_count 1, 2, 2; err_clr asserted on the next overflow capture edge -> err_count=0.
REQ-036 Preload err_count to 255 via 255 overflow results, one more overflow -> err_count stays 255.
REQ-037 Assert reset in the 2nd WAIT cycle, release, issue new pair -> no res_valid from aborted op, all outputs 0 during reset, new op completes with correct latency.
REQ-038 Rebuild with FPU_LATENCY=1 -> res_valid 2 cycles after acceptance; back-to-back in_valid with res_ready=1 -> accept interval exactly 3 cycles.

Source files
------------

// File: rtl/fpu_op_sequencer.sv
// Issues one operand pair to a fixed-latency fpu, waits out its latency,
// captures data/status, holds the result for a handshake, and counts range errors.
module fpu_op_sequencer #(
  parameter int unsigned FPU_LATENCY = 4
) (
  input  logic        clock100KHz,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] op_A_out,
  output logic [31:0] op_B_out,
  input  logic [31:0] fpu_data_in,
  input  logic [3:0]  fpu_status_in,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [3:0]  res_status,
  input  logic        err_clr,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(FPU_LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic        vld_q, vld_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  rstat_q, rstat_d;
  logic [7:0]  err_q, err_d;
  logic        capture;
  logic        range_err;

  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      vld_q   <= 1'b0;
      rdata_q <= '0;
      rstat_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      vld_q   <= vld_d;
      rdata_q <= rdata_d;
      rstat_q <= rstat_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    vld_d   = vld_q;
    rdata_d = rdata_q;
    rstat_d = rstat_q;
    capture = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (in_valid) begin
          op_a_d  = in_a;
          op_b_d  = in_b;
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      (state_q == WAIT): begin
        if (cnt_q == 4'd0) begin
          capture = 1'b1;
          rdata_d = fpu_data_in;
          rstat_d = fpu_status_in;
          vld_d   = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      (state_q == HOLD): begin
        if (res_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        vld_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign range_err = fpu_status_in[3] | fpu_status_in[2];

  // clear takes priority over a coincident increment
  always_comb begin
    err_d = err_q;
    if (err_clr) begin
      err_d = 8'd0;
    end else if (capture && range_err && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  assign in_ready   = (state_q == IDLE) && reset;
  assign op_A_out   = op_a_q;
  assign op_B_out   = op_b_q;
  assign res_valid  = vld_q;
  assign res_data   = rdata_q;
  assign res_status = rstat_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Scoreboard bench for fpu_op_sequencer: latency-4 instance for the main
// flow and a latency-1 instance for back-to-back issue spacing.
module tb_fpu_op_sequencer;
  localparam int LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0, in_b = '0;
  logic [31:0] op_A_out, op_B_out;
  logic [31:0] fpu_data_in = '0;
  logic [3:0]  fpu_status_in = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic [3:0]  res_status;
  logic        err_clr = 1'b0;
  logic [7:0]  err_count;

  logic        v1 = 1'b0;
  logic        r1;
  logic [31:0] a1 = 32'h3F800000, b1 = 32'h40000000;
  logic [31:0] oa1, ob1;
  logic [31:0] fd1 = 32'hC0DE0001;
  logic [3:0]  fs1 = 4'b0001;
  logic        rv1;
  logic        rr1 = 1'b0;
  logic [31:0] rd1;
  logic [3:0]  rs1;
  logic        ec1 = 1'b0;
  logic [7:0]  en1;

  fpu_op_sequencer #(.FPU_LATENCY(LAT)) dut (
    .clock100KHz(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .op_A_out(op_A_out), .op_B_out(op_B_out),
    .fpu_data_in(fpu_data_in), .fpu_status_in(fpu_status_in),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_status(res_status),
    .err_clr(err_clr), .err_count(err_count)
  );

  fpu_op_sequencer #(.FPU_LATENCY(1)) dut1 (
    .clock100KHz(clk), .reset(reset),
    .in_valid(v1), .in_ready(r1),
    .in_a(a1), .in_b(b1),
    .op_A_out(oa1), .op_B_out(ob1),
    .fpu_data_in(fd1), .fpu_status_in(fs1),
    .res_valid(rv1), .res_ready(rr1),
    .res_data(rd1), .res_status(rs1),
    .err_clr(ec1), .err_count(en1)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [7:0]  e;
  } exp_t;

  exp_t       q[$];
  exp_t       popped;
  int         acc1_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         acc_cyc = 0;
  logic [7:0] err_m = 8'd0;
  bit         prev = 1'b0;
  bit         prev1 = 1'b0;

  task automatic chk(input string n, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", n, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // acceptance happens at the next rising edge
  always @(negedge clk) begin
    #3;
    if (reset && in_valid && in_ready) acc_cyc = cyc;
    if (reset && v1 && r1) acc1_q.push_back(cyc);
  end

  always @(negedge clk) begin
    if (!reset) begin
      prev  = 1'b0;
      prev1 = 1'b0;
    end else begin
      if (res_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_res act=%0h exp=none", res_data);
        end else begin
          if (!prev) begin
            chk("latency", 128'(cyc - acc_cyc), 128'(LAT + 1));
            chk("err_count", err_count, q[0].e);
          end
          chk("res_data", res_data, q[0].d);
          chk("res_status", res_status, q[0].s);
          chk("op_a_stable", op_A_out, q[0].a);
          chk("in_ready_busy", in_ready, 0);
        end
      end else if (prev && q.size() != 0) begin
        chk("res_data_kept", res_data, q[0].d);
        chk("in_ready_idle", in_ready, 1);
        popped = q.pop_front();
      end
      prev = res_valid;
      if (rv1 && !prev1) begin
        if (acc1_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL lat1_noaccept act=none exp=accept");
        end else begin
          chk("lat1", 128'(cyc - acc1_q[$]), 128'd2);
        end
        chk("res_data1", rd1, 32'hC0DE0001);
      end
      prev1 = rv1;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] d, input logic [3:0] s,
                       input bit clr, input int hold);
    exp_t e;
    int   t;
    t = 0;
    tick();
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) begin
      total++;
      bad++;
      $display("FAIL issue_timeout act=busy exp=ready");
      return;
    end
    if (clr) err_m = 8'd0;
    else if ((s[3] || s[2]) && err_m != 8'hFF) err_m = err_m + 8'd1;
    e.a = a;
    e.d = d;
    e.s = s;
    e.e = err_m;
    q.push_back(e);
    in_valid      = 1'b1;
    in_a          = a;
    in_b          = b;
    fpu_data_in   = d;
    fpu_status_in = s;
    tick();
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    repeat (LAT - 1) tick();
    err_clr = clr;
    tick();
    err_clr = 1'b0;
    for (int i = 0; i < hold; i++) begin
      fpu_data_in = $urandom;
      in_a        = $urandom;
      in_valid    = 1'b1;
      tick();
    end
    in_valid  = 1'b1;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic chk_zero(input string n);
    chk(n, {op_A_out, op_B_out, res_data, res_status,
            res_valid, err_count, in_ready}, 128'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (3) tick();
    chk_zero("reset_state");
    reset = 1'b1;
    #1;
    chk("in_ready_after_rst", in_ready, 1);

    issue(32'h40400000, 32'h3FC00000, 32'h40900000, 4'b0001, 0, 10);
    issue(32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b1000, 0, 0);
    issue(32'h00800000, 32'h00800000, 32'h00000000, 4'b0100, 0, 1);
    issue(32'h3F800000, 32'h3DCCCCCD, 32'h3F8CCCCD, 4'b0010, 0, 0);
    issue(32'h7F000000, 32'h7F400000, 32'h7F800000, 4'b1000, 1, 0);

    for (int i = 0; i < 255; i++)
      issue(32'(i), 32'h7F7FFFFF, 32'h7F800000 | 32'(i), 4'b1000, 0, 0);
    issue(32'hAAAA5555, 32'h7F7FFFFF, 32'h7F800000, 4'b1010, 0, 2);

    tick();
    in_valid    = 1'b1;
    in_a        = 32'hDEADBEEF;
    in_b        = 32'hFEEDFACE;
    fpu_data_in = 32'h12345678;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk_zero("abort_rst0");
    err_m = 8'd0;
    repeat (3) begin
      tick();
      chk_zero("abort_rst");
    end
    reset = 1'b1;
    issue(32'h41200000, 32'h40A00000, 32'h41700000, 4'b0001, 0, 3);

    tick();
    v1  = 1'b1;
    rr1 = 1'b1;
    repeat (12) tick();
    v1 = 1'b0;
    repeat (4) tick();
    chk("accepts1", acc1_q.size() >= 4, 1);
    for (int i = 1; i < acc1_q.size(); i++)
      chk("interval1", 128'(acc1_q[i] - acc1_q[i-1]), 128'd3);

    t = 0;
    while (q.size() != 0 && t < 50) begin
      tick();
      t++;
    end
    chk("queue_drained", 128'(q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
